// File: rtl/feather_pkg.sv
// Shared definitions for the flag/condition path.
// Holds the ARM condition code enum, the NZCV bit positions shared with the
// ALU, and the output-buffer state encoding used by cond_unit.
package feather_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator, shared with branch logic.
// Ports:
//   cond  - 4-bit condition code
//   nzcv  - flags to test against (bit3=N, bit2=Z, bit1=C, bit0=V)
//   pass  - 1 when the condition holds
module cond_eval
  import feather_pkg::*;
(
  input  cond_t      cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;  // no "never" encoding on this core
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: architectural NZCV register, per-instruction condition
// evaluation, 2-entry result buffer and saturating executed/skipped counters.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   in_valid/in_ready             - instruction handshake
//   in_cond, in_tag               - condition code and tag of the instruction
//   in_flag_we, in_flag_mask      - flag write enable and per-bit mask
//   in_nzcv                       - new flags from the ALU
//   out_valid/out_ready           - result handshake
//   out_pass, out_tag             - head result
//   flags                         - current NZCV register
//   exec_cnt, skip_cnt            - saturating pass/fail counters
//
// Buffer states:
//   state     | meaning
//   BUF_EMPTY | no result held, out_valid low
//   BUF_ONE   | one result in head
//   BUF_TWO   | head and tail full, in_ready low
module cond_unit
  import feather_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_flag_we,
  input  logic [3:0]       in_flag_mask,
  input  logic [3:0]       in_nzcv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pass,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  buf_state_t       state, state_nxt;
  logic             accept, pop, cond_pass;
  logic             load_head, load_tail, shift_tail;
  logic             tail_pass;
  logic [TAG_W-1:0] tail_tag;
  cond_t            cond_e;

  assign cond_e = cond_t'(in_cond);

  cond_eval u_cond_eval (
    .cond (cond_e),
    .nzcv (flags),
    .pass (cond_pass)
  );

  // Handshakes derived from the state register so in_ready never depends on
  // out_ready combinationally.
  assign accept = in_valid && (state != BUF_TWO);
  assign pop    = (state != BUF_EMPTY) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY: if (accept) state_nxt = BUF_ONE;
      BUF_ONE: begin
        if (accept && !pop)      state_nxt = BUF_TWO;
        else if (pop && !accept) state_nxt = BUF_EMPTY;
      end
      BUF_TWO:   if (pop) state_nxt = BUF_ONE;
      default:   state_nxt = BUF_EMPTY;
    endcase
  end

  always_comb begin
    in_ready   = (state != BUF_TWO);
    out_valid  = (state != BUF_EMPTY);
    // A new result goes straight to head when head is free or leaving now.
    load_head  = accept && ((state == BUF_EMPTY) || (state == BUF_ONE && pop));
    load_tail  = accept && (state == BUF_ONE) && !pop;
    shift_tail = pop && (state == BUF_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pass  <= 1'b0;
      out_tag   <= '0;
      tail_pass <= 1'b0;
      tail_tag  <= '0;
    end else begin
      if (load_head) begin
        out_pass <= cond_pass;
        out_tag  <= in_tag;
      end else if (shift_tail) begin
        out_pass <= tail_pass;
        out_tag  <= tail_tag;
      end
      if (load_tail) begin
        tail_pass <= cond_pass;
        tail_tag  <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (accept && cond_pass && in_flag_we) begin
      flags <= (flags & ~in_flag_mask) | (in_nzcv & in_flag_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt <= '0;
      skip_cnt <= '0;
    end else if (accept) begin
      if (cond_pass) begin
        if (exec_cnt != '1) exec_cnt <= exec_cnt + 1'b1;
      end else begin
        if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_cond;
  logic [3:0] in_tag;
  logic       in_flag_we;
  logic [3:0] in_flag_mask;
  logic [3:0] in_nzcv;
  logic       out_ready;

  logic        in_ready, out_valid, out_pass;
  logic [3:0]  out_tag, flags;
  logic [15:0] exec_cnt, skip_cnt;

  logic        in_ready2, out_valid2, out_pass2;
  logic [3:0]  out_tag2, flags2;
  logic [1:0]  exec_cnt2, skip_cnt2;

  always #5 clk = ~clk;

  cond_unit #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_tag(in_tag), .in_flag_we(in_flag_we),
    .in_flag_mask(in_flag_mask), .in_nzcv(in_nzcv), .out_valid(out_valid),
    .out_ready(out_ready), .out_pass(out_pass), .out_tag(out_tag),
    .flags(flags), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
  );

  // Narrow-counter instance on the same stimulus to exercise saturation.
  cond_unit #(.TAG_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_cond(in_cond), .in_tag(in_tag), .in_flag_we(in_flag_we),
    .in_flag_mask(in_flag_mask), .in_nzcv(in_nzcv), .out_valid(out_valid2),
    .out_ready(out_ready), .out_pass(out_pass2), .out_tag(out_tag2),
    .flags(flags2), .exec_cnt(exec_cnt2), .skip_cnt(skip_cnt2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic [4:0] m_q[$];   // {pass, tag}
  int         m_exec, m_skip;

  typedef struct {
    logic [3:0] cond;
    logic       we;
    logic [3:0] mask;
    logic [3:0] nz;
    logic       exp_pass;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_q.delete();
    m_exec = 0;
    m_skip = 0;
  endtask

  task automatic check_all();
    check("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("out_pass", 32'(out_pass), 32'(m_q[0][4]));
      check("out_tag", 32'(out_tag), 32'(m_q[0][3:0]));
      check("out_pass2", 32'(out_pass2), 32'(m_q[0][4]));
      check("out_tag2", 32'(out_tag2), 32'(m_q[0][3:0]));
    end
    check("flags", 32'(flags), 32'(m_flags));
    check("exec_cnt", 32'(exec_cnt), 32'(sat(m_exec, 65535)));
    check("skip_cnt", 32'(skip_cnt), 32'(sat(m_skip, 65535)));
    check("in_ready2", 32'(in_ready2), 32'(m_q.size() < 2));
    check("out_valid2", 32'(out_valid2), 32'(m_q.size() > 0));
    check("flags2", 32'(flags2), 32'(m_flags));
    check("exec_cnt2", 32'(exec_cnt2), 32'(sat(m_exec, 3)));
    check("skip_cnt2", 32'(skip_cnt2), 32'(sat(m_skip, 3)));
  endtask

  task automatic cycle(input logic v, input logic [3:0] c, input logic [3:0] t,
                       input logic we, input logic [3:0] mask, input logic [3:0] nz,
                       input logic ordy);
    logic acc, pop, p;
    in_valid = v; in_cond = c; in_tag = t; in_flag_we = we;
    in_flag_mask = mask; in_nzcv = nz; out_ready = ordy;
    acc = v && (m_q.size() < 2);
    pop = (m_q.size() > 0) && ordy;
    p   = ref_pass(c, m_flags);
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back({p, t});
      if (p) m_exec++; else m_skip++;
      if (p && we) m_flags = (m_flags & ~mask) | (nz & mask);
    end
    #1;
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_flags"}, 32'(flags), 32'h0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_pass"}, 32'(out_pass), 32'h0);
    check({tag, "_out_tag"}, 32'(out_tag), 32'h0);
    check({tag, "_exec"}, 32'(exec_cnt), 32'h0);
    check({tag, "_skip"}, 32'(skip_cnt), 32'h0);
    check({tag, "_exec2"}, 32'(exec_cnt2), 32'h0);
  endtask

  initial begin
    //           cond   we    mask     nzcv     pass  flags after
    tbl[0] = '{4'h0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000}; // EQ, Z=0
    tbl[1] = '{4'hE, 1'b1, 4'b1111, 4'b0100, 1'b1, 4'b0100}; // AL sets Z
    tbl[2] = '{4'h0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0100}; // EQ sees new Z
    tbl[3] = '{4'hE, 1'b1, 4'b1111, 4'b1001, 1'b1, 4'b1001};
    tbl[4] = '{4'hE, 1'b1, 4'b1100, 4'b0110, 1'b1, 4'b0101}; // masked write
    tbl[5] = '{4'hA, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0101}; // GE, N=0 V=1
    tbl[6] = '{4'hB, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0101}; // LT
    tbl[7] = '{4'hE, 1'b1, 4'b1111, 4'b0100, 1'b1, 4'b0100};
    tbl[8] = '{4'h1, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0100}; // failed NE, no write

    rst_n = 1'b0;
    in_valid = 1'b0; in_cond = '0; in_tag = '0; in_flag_we = 1'b0;
    in_flag_mask = '0; in_nzcv = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_values("rst");

    // Table vectors, one per cycle with the consumer always ready.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, tbl[i].cond, 4'(i), tbl[i].we, tbl[i].mask, tbl[i].nz, 1'b1);
      check($sformatf("tbl%0d_pass", i), 32'(out_pass), 32'(tbl[i].exp_pass));
      check($sformatf("tbl%0d_tag", i), 32'(out_tag), 32'(i));
      check($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].exp_flags));
    end
    check("tbl_exec_total", 32'(exec_cnt), 32'd6);
    check("tbl_skip_total", 32'(skip_cnt), 32'd3);
    check("tbl_exec_sat2", 32'(exec_cnt2), 32'd3);
    check("tbl_skip2", 32'(skip_cnt2), 32'd3);

    // Drain, then stall the consumer for three cycles.
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    check("drain_empty", 32'(out_valid), 32'h0);
    cycle(1'b1, 4'hE, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0);
    check("stall1_tag", 32'(out_tag), 32'h5);
    cycle(1'b1, 4'hE, 4'h6, 1'b0, 4'h0, 4'h0, 1'b0);
    check("stall2_tag", 32'(out_tag), 32'h5);
    check("stall2_full", 32'(in_ready), 32'h0);
    cycle(1'b1, 4'hE, 4'h7, 1'b0, 4'h0, 4'h0, 1'b0);
    check("stall3_tag", 32'(out_tag), 32'h5);
    check("stall3_full", 32'(in_ready), 32'h0);
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    check("rel1_tag", 32'(out_tag), 32'h6);
    check("rel1_valid", 32'(out_valid), 32'h1);
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    check("rel2_valid", 32'(out_valid), 32'h0);

    // Random traffic against the model, with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
            1'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
